// File: rtl/mem_access_ctrl_if.sv
// Data-bus side of the MEM-stage access controller: request fields out, accept/complete/read data back.
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: IDLE -> ADDR -> (DATA) -> DONE, stalls the pipe until the bus completes.
// Optional macro ADDR_ERR_CHECK_EN: trap misaligned accesses (adel/ades) instead of issuing them truncated.
module mem_access_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    output logic              stall_out,
    output logic [31:0]       mem_rdata,
    output logic              rdata_valid,
    output logic              adel,
    output logic              ades,
    mem_access_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        kill;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        req_ok;
    logic        accept;
    logic        capture;
    logic [31:0] addr_fix;
    logic [3:0]  wstrb_nxt;
    logic [31:0] wdata_nxt;

    assign is_byte    = (mem_size == 2'b00);
    assign is_half    = (mem_size == 2'b01);
    assign misaligned = (is_half & mem_addr[0]) | (!is_byte & !is_half & (mem_addr[1:0] != 2'b00));
    assign req_ok     = (state == S_IDLE) & mem_req & !flush & !rst;

`ifdef ADDR_ERR_CHECK_EN
    assign accept = req_ok & !misaligned;
    assign adel   = req_ok & misaligned & !mem_wr;
    assign ades   = req_ok & misaligned & mem_wr;
`else
    assign accept = req_ok;
    assign adel   = 1'b0;
    assign ades   = 1'b0;
`endif

    // Low address bits are forced to the access alignment; strobes follow the forced address.
    always_comb begin
        addr_fix = mem_addr;
        if (is_half) begin
            addr_fix[0] = 1'b0;
        end else if (!is_byte) begin
            addr_fix[1:0] = 2'b00;
        end
    end

    always_comb begin
        wstrb_nxt = 4'b0000;
        if (mem_wr) begin
            if (is_byte) begin
                case (addr_fix[1:0])
                    2'b00:   wstrb_nxt = 4'b1000;
                    2'b01:   wstrb_nxt = 4'b0100;
                    2'b10:   wstrb_nxt = 4'b0010;
                    default: wstrb_nxt = 4'b0001;
                endcase
            end else if (is_half) begin
                wstrb_nxt = addr_fix[1] ? 4'b0011 : 4'b1100;
            end else begin
                wstrb_nxt = 4'b1111;
            end
        end
    end

    always_comb begin
        if (is_byte) begin
            wdata_nxt = {4{mem_wdata[7:0]}};
        end else if (is_half) begin
            wdata_nxt = {2{mem_wdata[15:0]}};
        end else begin
            wdata_nxt = mem_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_ADDR;
            S_ADDR: if (bus.data_addr_ok) state_nxt = bus.data_data_ok ? S_DONE : S_DATA;
            S_DATA: if (bus.data_data_ok) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign capture = ((state == S_ADDR) & bus.data_addr_ok & bus.data_data_ok) |
                     ((state == S_DATA) & bus.data_data_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            kill      <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            mem_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q    <= mem_wr;
                size_q  <= mem_size;
                addr_q  <= addr_fix;
                wdata_q <= wdata_nxt;
                wstrb_q <= wstrb_nxt;
            end
            if (capture) begin
                mem_rdata <= bus.data_rdata;
            end
            // A flush mid-flight lets the bus finish but hides the result from the pipe.
            if (accept || state == S_DONE) begin
                kill <= 1'b0;
            end else if ((state == S_ADDR || state == S_DATA) && flush) begin
                kill <= 1'b1;
            end
        end
    end

    assign bus.data_req   = (state == S_ADDR);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_wdata = wdata_q;

    assign stall_out   = (state == S_ADDR) | (state == S_DATA) | accept;
    assign rdata_valid = (state == S_DONE) & !wr_q & !kill;
endmodule
